// File: rtl/turbo_rx_deframer.sv
// Receive-side turbo code block deframer: splits data beats into indexed sys/parity triples
// and collects trellis tail bits. Optional macro TURBO_RX_GAP_ERR_EN turns input gaps into framing errors.
module turbo_rx_deframer #(
  parameter int K_SHORT     = 4,
  parameter int K_LONG      = 6,
  parameter int TAIL_CYCLES = 4,
  parameter int CNT_W       = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     length_flag,
  input  logic                     d0,
  input  logic                     d1,
  input  logic                     d2,
  output logic                     sys_bit,
  output logic                     par1_bit,
  output logic                     par2_bit,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         out_index,
  output logic [3*TAIL_CYCLES-1:0] tail_bits,
  output logic                     tail_valid,
  output logic                     block_done,
  output logic                     busy,
  output logic                     err
);

  localparam int TW = 3 * TAIL_CYCLES;
  localparam logic [CNT_W-1:0] C_K_SHORT  = CNT_W'(K_SHORT);
  localparam logic [CNT_W-1:0] C_K_LONG   = CNT_W'(K_LONG);
  localparam logic [CNT_W-1:0] C_TAIL_END = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_klen;
  logic             r_sys, r_par1, r_par2, r_out_valid;
  logic [CNT_W-1:0] r_out_index;
  logic [TW-1:0]    r_tail_bits;
  logic             r_tail_valid, r_block_done, r_busy, r_err;
  logic [CNT_W-1:0] w_klen;

  assign w_klen = length_flag ? C_K_LONG : C_K_SHORT;

  // DONE accepts a new beat 0 exactly like IDLE, which gives gapless back-to-back blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_klen       <= C_K_SHORT;
      r_sys        <= 1'b0;
      r_par1       <= 1'b0;
      r_par2       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_tail_bits  <= '0;
      r_tail_valid <= 1'b0;
      r_block_done <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_block_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (in_valid) begin
            r_klen       <= w_klen;
            r_sys        <= d0;
            r_par1       <= d1;
            r_par2       <= d2;
            r_out_valid  <= 1'b1;
            r_out_index  <= '0;
            r_tail_bits  <= '0;
            r_tail_valid <= 1'b0;
            r_busy       <= 1'b1;
            // A one-beat block goes straight to the tail, whose beat count starts at zero.
            if (w_klen == C_ONE) begin
              r_state <= S_TAIL;
              r_cnt   <= '0;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= C_ONE;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            r_sys       <= d0;
            r_par1      <= d1;
            r_par2      <= d2;
            r_out_valid <= 1'b1;
            r_out_index <= r_cnt;
            if (r_cnt == r_klen - C_ONE) begin
              r_state <= S_TAIL;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
`ifdef TURBO_RX_GAP_ERR_EN
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_tail_valid <= 1'b0;
`endif
          end
        end
        S_TAIL: begin
          if (in_valid) begin
            r_tail_bits <= {r_tail_bits[TW-4:0], d0, d1, d2};
            if (r_cnt == C_TAIL_END) begin
              r_state      <= S_DONE;
              r_cnt        <= '0;
              r_busy       <= 1'b0;
              r_block_done <= 1'b1;
              r_tail_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
`ifdef TURBO_RX_GAP_ERR_EN
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_tail_valid <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sys_bit    = r_sys;
  assign par1_bit   = r_par1;
  assign par2_bit   = r_par2;
  assign out_valid  = r_out_valid;
  assign out_index  = r_out_index;
  assign tail_bits  = r_tail_bits;
  assign tail_valid = r_tail_valid;
  assign block_done = r_block_done;
  assign busy       = r_busy;
`ifdef TURBO_RX_GAP_ERR_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_turbo_rx_deframer.sv
// Scoreboard bench for turbo_rx_deframer: data triples and tail registers are predicted as beats are driven
// and compared when the DUT raises out_valid / block_done.
module tb_turbo_rx_deframer;

  localparam int CNT_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              length_flag = 1'b0;
  logic              d0 = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic              sys_bit, par1_bit, par2_bit, out_valid;
  logic [CNT_W-1:0]  out_index;
  logic [11:0]       tail_bits;
  logic              tail_valid, block_done, busy, err;

  typedef struct {
    logic [11:0] tail;
    int          cyc;
  } done_t;

  logic [16:0] expQ[$];
  done_t       doneQ[$];
  logic [16:0] expData;
  done_t       expDone;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  turbo_rx_deframer #(.K_SHORT(4), .K_LONG(6), .TAIL_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .length_flag(length_flag),
    .d0(d0), .d1(d1), .d2(d2),
    .sys_bit(sys_bit), .par1_bit(par1_bit), .par2_bit(par2_bit),
    .out_valid(out_valid), .out_index(out_index),
    .tail_bits(tail_bits), .tail_valid(tail_valid), .block_done(block_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_outs"}, {sys_bit, par1_bit, par2_bit, out_valid, tail_valid, block_done, busy, err}, 0);
    chk({tag, "_index"}, 32'(out_index), 0);
    chk({tag, "_tail"}, 32'(tail_bits), 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one block: data triple i sits in data[3*i +: 3] as {d0,d1,d2}; tail triples are MSB-first.
  task automatic sendBlock(input logic lf, input int k, input logic [17:0] data, input logic [11:0] tail,
                           input int gapAfter, input int gapLen, input int resetAt, input bit b2b);
    int start;
    int extra;
    logic [2:0] t;
    start = cyc + 1;
    extra = (gapAfter >= 0) ? gapLen : 0;
    for (int i = 0; i < k + 4; i++) begin
      if (i < k) begin
        t = data[3*i +: 3];
        expQ.push_back({14'(i), t});
      end else begin
        t = tail[11 - 3*(i-k) -: 3];
      end
      in_valid    = 1'b1;
      length_flag = (i == 0) ? lf : ~lf;
      {d0, d1, d2} = t;
      if (i == resetAt) reset = 1'b1;
      @(posedge clk); #1;
      if (i == resetAt) begin
        checkAllZero("reset_mid_tail");
        reset    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (i == 0) begin
        chk("busy_after_beat0", 32'(busy), 1);
        chk("tail_valid_cleared", 32'(tail_valid), 0);
      end
      if (i == gapAfter) begin
        in_valid = 1'b0;
        for (int g = 0; g < gapLen; g++) begin
          @(posedge clk); #1;
          chk("gap_out_valid", 32'(out_valid), 0);
`ifdef TURBO_RX_GAP_ERR_EN
          chk("gap_err", 32'(err), (g == 0) ? 1 : 0);
          chk("gap_busy", 32'(busy), 0);
`else
          chk("gap_err", 32'(err), 0);
          chk("gap_busy", 32'(busy), 1);
`endif
        end
`ifdef TURBO_RX_GAP_ERR_EN
        return;
`endif
      end
    end
    doneQ.push_back('{tail: tail, cyc: start + k + 3 + extra});
    chk("busy_in_done", 32'(busy), 0);
    if (!b2b) in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (expQ.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          expData = expQ.pop_front();
          chk("data_triple", {15'd0, out_index, sys_bit, par1_bit, par2_bit}, {15'd0, expData});
        end
      end
      if (block_done) begin
        if (doneQ.size() == 0) chk("unexpected_block_done", 1, 0);
        else begin
          expDone = doneQ.pop_front();
          chk("tail_bits", 32'(tail_bits), 32'(expDone.tail));
          chk("tail_valid_at_done", 32'(tail_valid), 1);
          chk("done_cycle", 32'(cyc), 32'(expDone.cyc));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    reset = 1'b0;
    idle(2);
    sendBlock(1'b0, 4, 18'b000000_001_110_011_101, 12'b111_000_101_010, -1, 0, -1, 1'b0);
    idle(1);
    chk("tail_valid_held", 32'(tail_valid), 1);
    chk("tail_bits_held", 32'(tail_bits), 32'(12'b111000101010));
    idle(1);
    sendBlock(1'b1, 6, 18'b100_010_111_000_110_101, 12'b010_110_001_111, -1, 0, -1, 1'b1);
    sendBlock(1'b0, 4, 18'b000000_111_000_100_010, 12'b101_101_010_011, -1, 0, -1, 1'b0);
    idle(2);
    sendBlock(1'b0, 4, 18'b000000_010_101_011_110, 12'b001_011_111_100, 2, 2, -1, 1'b0);
    idle(2);
    sendBlock(1'b0, 4, 18'b000000_110_001_101_011, 12'b100_100_100_100, -1, 0, 6, 1'b0);
    idle(1);
    sendBlock(1'b1, 6, 18'b011_101_000_111_001_100, 12'b110_011_000_101, -1, 0, -1, 1'b0);
    idle(3);
    chk("data_queue_drained", 32'(expQ.size()), 0);
    chk("done_queue_drained", 32'(doneQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
